decode_issue_ctrl: RTL and testbench

//  Registered RV32IM decode/issue stage. Takes one 32-bit instruction per valid/ready handshake,

---
 rtl/rv_ctrl_pkg.sv | 66 ++++++
 rtl/rv_decode_comb.sv | 164 ++++++++++++++++
 rtl/decode_issue_ctrl.sv | 148 ++++++++++++++
 tb/tb_decode_issue_ctrl.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/rv_ctrl_pkg.sv
// Shared RV32IM control definitions: ALU control codes, major opcodes,
// issue FSM states and the datapath control bundle.
package rv_ctrl_pkg;

  localparam logic [4:0] ALUCTRL_NOP    = 5'd0;
  localparam logic [4:0] ALUCTRL_ADD    = 5'd1;
  localparam logic [4:0] ALUCTRL_SUB    = 5'd2;
  localparam logic [4:0] ALUCTRL_SLL    = 5'd3;
  localparam logic [4:0] ALUCTRL_SLT    = 5'd4;
  localparam logic [4:0] ALUCTRL_SLTU   = 5'd5;
  localparam logic [4:0] ALUCTRL_XOR    = 5'd6;
  localparam logic [4:0] ALUCTRL_SRL    = 5'd7;
  localparam logic [4:0] ALUCTRL_SRA    = 5'd8;
  localparam logic [4:0] ALUCTRL_OR     = 5'd9;
  localparam logic [4:0] ALUCTRL_AND    = 5'd10;
  localparam logic [4:0] ALUCTRL_MUL    = 5'd11;
  localparam logic [4:0] ALUCTRL_MULH   = 5'd12;
  localparam logic [4:0] ALUCTRL_MULHSU = 5'd13;
  localparam logic [4:0] ALUCTRL_MULHU  = 5'd14;
  localparam logic [4:0] ALUCTRL_DIV    = 5'd15;
  localparam logic [4:0] ALUCTRL_DIVU   = 5'd16;
  localparam logic [4:0] ALUCTRL_REM    = 5'd17;
  localparam logic [4:0] ALUCTRL_REMU   = 5'd18;
  localparam logic [4:0] ALUCTRL_BEQ    = 5'd19;
  localparam logic [4:0] ALUCTRL_BNE    = 5'd20;
  localparam logic [4:0] ALUCTRL_BLT    = 5'd21;
  localparam logic [4:0] ALUCTRL_BGE    = 5'd22;
  localparam logic [4:0] ALUCTRL_BLTU   = 5'd23;
  localparam logic [4:0] ALUCTRL_BGEU   = 5'd24;
  localparam logic [4:0] ALUCTRL_JAL    = 5'd25;
  localparam logic [4:0] ALUCTRL_JALR   = 5'd26;

  localparam logic [6:0] OPC_R      = 7'b011_0011;
  localparam logic [6:0] OPC_I_CALC = 7'b001_0011;
  localparam logic [6:0] OPC_LOAD   = 7'b000_0011;
  localparam logic [6:0] OPC_STORE  = 7'b010_0011;
  localparam logic [6:0] OPC_BRANCH = 7'b110_0011;
  localparam logic [6:0] OPC_JAL    = 7'b110_1111;
  localparam logic [6:0] OPC_JALR   = 7'b110_0111;
  localparam logic [6:0] OPC_AUIPC  = 7'b001_0111;
  localparam logic [6:0] OPC_LUI    = 7'b011_0111;

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_MWAIT = 1'b1
  } issue_state_t;

  typedef struct packed {
    logic [4:0] alu_ctrl;
    logic       branch;
    logic       mem_read;
    logic       mem_to_reg;
    logic       mem_write;
    logic       alu_src;
    logic       reg_write;
    logic [4:0] rd;
  } ctrl_bundle_t;

  function automatic ctrl_bundle_t ctrl_nop();
    ctrl_bundle_t b;
    b = '0;
    b.alu_ctrl = ALUCTRL_NOP;
    return b;
  endfunction

endpackage

// File: rtl/rv_decode_comb.sv
// Pure combinational RV32IM decoder: instruction word to control bundle,
// illegal flag and multi-cycle M-extension class.
module rv_decode_comb
  import rv_ctrl_pkg::*;
#(
  parameter bit ENABLE_M = 1'b1
) (
  input  logic [31:0]  instr,
  output ctrl_bundle_t bundle,
  output logic         illegal,
  output logic         is_mul,
  output logic         is_div
);

  logic [6:0]   opcode_s;
  logic [2:0]   funct3_s;
  logic [6:0]   funct7_s;
  logic         ill_s;
  ctrl_bundle_t dec_s;
  logic         unused_rs_bits;

  assign opcode_s = instr[6:0];
  assign funct3_s = instr[14:12];
  assign funct7_s = instr[31:25];
  assign unused_rs_bits = &{1'b0, instr[24:15]};

  // Opcode/funct decode; illegal encodings collapse to a NOP bundle.
  always_comb begin
    dec_s  = ctrl_nop();
    ill_s  = 1'b0;
    is_mul = 1'b0;
    is_div = 1'b0;
    case (opcode_s)
      OPC_R: begin
        dec_s.reg_write = 1'b1;
        case (funct7_s)
          7'b000_0000: begin
            case (funct3_s)
              3'b000:  dec_s.alu_ctrl = ALUCTRL_ADD;
              3'b001:  dec_s.alu_ctrl = ALUCTRL_SLL;
              3'b010:  dec_s.alu_ctrl = ALUCTRL_SLT;
              3'b011:  dec_s.alu_ctrl = ALUCTRL_SLTU;
              3'b100:  dec_s.alu_ctrl = ALUCTRL_XOR;
              3'b101:  dec_s.alu_ctrl = ALUCTRL_SRL;
              3'b110:  dec_s.alu_ctrl = ALUCTRL_OR;
              3'b111:  dec_s.alu_ctrl = ALUCTRL_AND;
              default: ill_s = 1'b1;
            endcase
          end
          7'b010_0000: begin
            case (funct3_s)
              3'b000:  dec_s.alu_ctrl = ALUCTRL_SUB;
              3'b101:  dec_s.alu_ctrl = ALUCTRL_SRA;
              default: ill_s = 1'b1;
            endcase
          end
          7'b000_0001: begin
            if (ENABLE_M) begin
              is_mul = ~funct3_s[2];
              is_div = funct3_s[2];
              case (funct3_s)
                3'b000:  dec_s.alu_ctrl = ALUCTRL_MUL;
                3'b001:  dec_s.alu_ctrl = ALUCTRL_MULH;
                3'b010:  dec_s.alu_ctrl = ALUCTRL_MULHSU;
                3'b011:  dec_s.alu_ctrl = ALUCTRL_MULHU;
                3'b100:  dec_s.alu_ctrl = ALUCTRL_DIV;
                3'b101:  dec_s.alu_ctrl = ALUCTRL_DIVU;
                3'b110:  dec_s.alu_ctrl = ALUCTRL_REM;
                3'b111:  dec_s.alu_ctrl = ALUCTRL_REMU;
                default: ill_s = 1'b1;
              endcase
            end else begin
              ill_s = 1'b1;
            end
          end
          default: ill_s = 1'b1;
        endcase
      end
      OPC_I_CALC: begin
        dec_s.reg_write = 1'b1;
        dec_s.alu_src   = 1'b1;
        case (funct3_s)
          3'b000: dec_s.alu_ctrl = ALUCTRL_ADD;
          3'b010: dec_s.alu_ctrl = ALUCTRL_SLT;
          3'b011: dec_s.alu_ctrl = ALUCTRL_SLTU;
          3'b100: dec_s.alu_ctrl = ALUCTRL_XOR;
          3'b110: dec_s.alu_ctrl = ALUCTRL_OR;
          3'b111: dec_s.alu_ctrl = ALUCTRL_AND;
          3'b001: begin
            if (funct7_s == 7'b000_0000) begin
              dec_s.alu_ctrl = ALUCTRL_SLL;
            end else begin
              ill_s = 1'b1;
            end
          end
          3'b101: begin
            if (funct7_s == 7'b000_0000) begin
              dec_s.alu_ctrl = ALUCTRL_SRL;
            end else if (funct7_s == 7'b010_0000) begin
              dec_s.alu_ctrl = ALUCTRL_SRA;
            end else begin
              ill_s = 1'b1;
            end
          end
          default: ill_s = 1'b1;
        endcase
      end
      OPC_LOAD: begin
        dec_s.alu_ctrl   = ALUCTRL_ADD;
        dec_s.mem_read   = 1'b1;
        dec_s.mem_to_reg = 1'b1;
        dec_s.alu_src    = 1'b1;
        dec_s.reg_write  = 1'b1;
      end
      OPC_STORE: begin
        dec_s.alu_ctrl  = ALUCTRL_ADD;
        dec_s.mem_write = 1'b1;
        dec_s.alu_src   = 1'b1;
      end
      OPC_BRANCH: begin
        dec_s.branch = 1'b1;
        case (funct3_s)
          3'b000:  dec_s.alu_ctrl = ALUCTRL_BEQ;
          3'b001:  dec_s.alu_ctrl = ALUCTRL_BNE;
          3'b100:  dec_s.alu_ctrl = ALUCTRL_BLT;
          3'b101:  dec_s.alu_ctrl = ALUCTRL_BGE;
          3'b110:  dec_s.alu_ctrl = ALUCTRL_BLTU;
          3'b111:  dec_s.alu_ctrl = ALUCTRL_BGEU;
          default: ill_s = 1'b1;
        endcase
      end
      OPC_JAL, OPC_JALR: begin
        dec_s.alu_ctrl  = (opcode_s == OPC_JAL) ? ALUCTRL_JAL : ALUCTRL_JALR;
        dec_s.branch    = 1'b1;
        dec_s.alu_src   = 1'b1;
        dec_s.reg_write = 1'b1;
      end
      OPC_AUIPC, OPC_LUI: begin
        dec_s.alu_ctrl  = ALUCTRL_ADD;
        dec_s.alu_src   = 1'b1;
        dec_s.reg_write = 1'b1;
      end
      default: ill_s = 1'b1;
    endcase

    // Writes to x0 are architecturally dropped.
    if (ill_s) begin
      dec_s  = ctrl_nop();
      is_mul = 1'b0;
      is_div = 1'b0;
    end else begin
      dec_s.rd = instr[11:7];
      if (dec_s.rd == 5'd0) begin
        dec_s.reg_write = 1'b0;
      end else begin
        dec_s.reg_write = dec_s.reg_write;
      end
    end
  end

  assign bundle  = dec_s;
  assign illegal = ill_s;

endmodule

// File: rtl/decode_issue_ctrl.sv
// RV32IM decode/issue stage: one-entry output register with valid/ready
// handshake, and a busy FSM that stalls issue while a MUL/DIV is in flight.
module decode_issue_ctrl
  import rv_ctrl_pkg::*;
#(
  parameter int XLEN        = 32,
  parameter bit ENABLE_M    = 1'b1,
  parameter int MUL_LATENCY = 3,
  parameter int DIV_LATENCY = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] instr,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [4:0]      alu_ctrl,
  output logic            branch,
  output logic            mem_read,
  output logic            mem_to_reg,
  output logic            mem_write,
  output logic            alu_src,
  output logic            reg_write,
  output logic [4:0]      rd,
  output logic            illegal,
  output logic            mext_busy
);

  localparam int MAX_LAT = (MUL_LATENCY > DIV_LATENCY) ? MUL_LATENCY : DIV_LATENCY;
  localparam int CNT_W   = (MAX_LAT < 1) ? 1 : $clog2(MAX_LAT + 1);
  localparam logic [CNT_W-1:0] MUL_CNT = CNT_W'(MUL_LATENCY);
  localparam logic [CNT_W-1:0] DIV_CNT = CNT_W'(DIV_LATENCY);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam bit MUL_MCYC = (MUL_LATENCY != 0);
  localparam bit DIV_MCYC = (DIV_LATENCY != 0);

  ctrl_bundle_t dec_bundle_s;
  logic         dec_illegal_s;
  logic         dec_is_mul_s;
  logic         dec_is_div_s;

  ctrl_bundle_t bundle_r;
  logic         illegal_r;
  logic         held_mul_r;
  logic         held_div_r;
  logic         out_valid_r;
  issue_state_t state_r;
  logic [CNT_W-1:0] cnt_r;
  logic         mext_busy_r;

  logic held_is_mcyc_s;
  logic accept_s;
  logic consume_s;

  rv_decode_comb #(
    .ENABLE_M (ENABLE_M)
  ) u_decode (
    .instr   (instr[31:0]),
    .bundle  (dec_bundle_s),
    .illegal (dec_illegal_s),
    .is_mul  (dec_is_mul_s),
    .is_div  (dec_is_div_s)
  );

  assign held_is_mcyc_s = (held_mul_r && MUL_MCYC) || (held_div_r && DIV_MCYC);
  assign in_ready  = (state_r == ST_RUN) && !flush &&
                     (!out_valid_r || (out_ready && !held_is_mcyc_s));
  assign accept_s  = in_valid && in_ready;
  // A flushed entry is discarded, never handed to execute.
  assign consume_s = out_valid_r && out_ready && !flush;

  // Output entry register: flush > load > consume > hold.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_r <= 1'b0;
      bundle_r    <= ctrl_nop();
      illegal_r   <= 1'b0;
      held_mul_r  <= 1'b0;
      held_div_r  <= 1'b0;
    end else if (flush) begin
      out_valid_r <= 1'b0;
    end else if (accept_s) begin
      out_valid_r <= 1'b1;
      bundle_r    <= dec_bundle_s;
      illegal_r   <= dec_illegal_s;
      held_mul_r  <= dec_is_mul_s;
      held_div_r  <= dec_is_div_s;
    end else if (consume_s) begin
      out_valid_r <= 1'b0;
    end else begin
      out_valid_r <= out_valid_r;
    end
  end

  // Busy FSM: counter counts down the M-op latency, busy flag registered alongside.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= ST_RUN;
      cnt_r       <= '0;
      mext_busy_r <= 1'b0;
    end else begin
      case (state_r)
        ST_RUN: begin
          if (consume_s && held_is_mcyc_s) begin
            state_r     <= ST_MWAIT;
            cnt_r       <= held_div_r ? DIV_CNT : MUL_CNT;
            mext_busy_r <= 1'b1;
          end else begin
            state_r     <= ST_RUN;
            cnt_r       <= '0;
            mext_busy_r <= 1'b0;
          end
        end
        ST_MWAIT: begin
          if (cnt_r == CNT_ONE) begin
            state_r     <= ST_RUN;
            cnt_r       <= '0;
            mext_busy_r <= 1'b0;
          end else begin
            state_r     <= ST_MWAIT;
            cnt_r       <= cnt_r - CNT_ONE;
            mext_busy_r <= 1'b1;
          end
        end
        default: begin
          state_r     <= ST_RUN;
          cnt_r       <= '0;
          mext_busy_r <= 1'b0;
        end
      endcase
    end
  end

  assign out_valid  = out_valid_r;
  assign alu_ctrl   = bundle_r.alu_ctrl;
  assign branch     = bundle_r.branch;
  assign mem_read   = bundle_r.mem_read;
  assign mem_to_reg = bundle_r.mem_to_reg;
  assign mem_write  = bundle_r.mem_write;
  assign alu_src    = bundle_r.alu_src;
  assign reg_write  = bundle_r.reg_write;
  assign rd         = bundle_r.rd;
  assign illegal    = illegal_r;
  assign mext_busy  = mext_busy_r;

endmodule

// File: tb/tb_decode_issue_ctrl.sv
// Self-checking bench for decode_issue_ctrl: directed scenarios plus random
// traffic against a cycle-level reference model of decode and issue timing.
module tb_decode_issue_ctrl;
  import rv_ctrl_pkg::*;

  localparam int MUL_LAT = 3;
  localparam int DIV_LAT = 4;

  localparam logic [31:0] I_ADD  = 32'h003100B3;
  localparam logic [31:0] I_DIV  = 32'h027342B3;
  localparam logic [31:0] I_SW   = 32'h00112023;
  localparam logic [31:0] I_MUL  = 32'h022081B3;
  localparam logic [31:0] I_ADDI = 32'h00100013;

  typedef struct packed {
    logic [4:0] alu;
    logic       br, mr, m2r, mw, asrc, rw;
    logic [4:0] rd;
    logic       ill;
    logic [1:0] mk;
  } exp_t;

  logic clk, rst;
  logic in_valid, in_ready, flush, out_valid, out_ready;
  logic [31:0] instr;
  logic [4:0] alu_ctrl, rd;
  logic branch, mem_read, mem_to_reg, mem_write, alu_src, reg_write, illegal, mext_busy;

  logic in_valid2, in_ready2, flush2, out_valid2, out_ready2;
  logic [31:0] instr2;
  logic [4:0] alu_ctrl2, rd2;
  logic branch2, mem_read2, mem_to_reg2, mem_write2, alu_src2, reg_write2, illegal2, mext_busy2;

  int checks = 0;
  int passes = 0;
  bit m_valid;
  exp_t m_ent;
  int m_busy;
  bit last_acc;

  decode_issue_ctrl #(.XLEN(32), .ENABLE_M(1'b1), .MUL_LATENCY(MUL_LAT), .DIV_LATENCY(DIV_LAT)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .instr(instr),
    .flush(flush), .out_valid(out_valid), .out_ready(out_ready), .alu_ctrl(alu_ctrl),
    .branch(branch), .mem_read(mem_read), .mem_to_reg(mem_to_reg), .mem_write(mem_write),
    .alu_src(alu_src), .reg_write(reg_write), .rd(rd), .illegal(illegal), .mext_busy(mext_busy)
  );

  decode_issue_ctrl #(.XLEN(32), .ENABLE_M(1'b0), .MUL_LATENCY(MUL_LAT), .DIV_LATENCY(DIV_LAT)) dut_nm (
    .clk(clk), .rst(rst), .in_valid(in_valid2), .in_ready(in_ready2), .instr(instr2),
    .flush(flush2), .out_valid(out_valid2), .out_ready(out_ready2), .alu_ctrl(alu_ctrl2),
    .branch(branch2), .mem_read(mem_read2), .mem_to_reg(mem_to_reg2), .mem_write(mem_write2),
    .alu_src(alu_src2), .reg_write(reg_write2), .rd(rd2), .illegal(illegal2), .mext_busy(mext_busy2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks = checks + 1;
    assert (obs === exp) passes = passes + 1;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Reference decode written from the ISA tables, not from the RTL structure.
  function automatic exp_t ref_dec(input logic [31:0] i, input bit enm);
    exp_t e;
    logic [4:0] rbase [8];
    logic [4:0] bbase [8];
    logic [2:0] f3;
    logic [6:0] f7;
    bit ill;
    rbase = '{ALUCTRL_ADD, ALUCTRL_SLL, ALUCTRL_SLT, ALUCTRL_SLTU,
              ALUCTRL_XOR, ALUCTRL_SRL, ALUCTRL_OR, ALUCTRL_AND};
    bbase = '{ALUCTRL_BEQ, ALUCTRL_BNE, ALUCTRL_NOP, ALUCTRL_NOP,
              ALUCTRL_BLT, ALUCTRL_BGE, ALUCTRL_BLTU, ALUCTRL_BGEU};
    e = '0; ill = 1'b0; f3 = i[14:12]; f7 = i[31:25];
    case (i[6:0])
      7'h33: begin
        e.rw = 1'b1;
        if (f7 == 7'h00) e.alu = rbase[f3];
        else if (f7 == 7'h20 && f3 == 3'd0) e.alu = ALUCTRL_SUB;
        else if (f7 == 7'h20 && f3 == 3'd5) e.alu = ALUCTRL_SRA;
        else if (f7 == 7'h01 && enm) begin
          e.alu = ALUCTRL_MUL + 5'(f3);
          e.mk = (f3 < 3'd4) ? 2'd1 : 2'd2;
        end else ill = 1'b1;
      end
      7'h13: begin
        e.rw = 1'b1; e.asrc = 1'b1;
        if (f3 == 3'd1 && f7 != 7'h00) ill = 1'b1;
        else if (f3 == 3'd5 && f7 == 7'h20) e.alu = ALUCTRL_SRA;
        else if (f3 == 3'd5 && f7 != 7'h00) ill = 1'b1;
        else e.alu = rbase[f3];
      end
      7'h03: begin e.alu = ALUCTRL_ADD; e.mr = 1'b1; e.m2r = 1'b1; e.asrc = 1'b1; e.rw = 1'b1; end
      7'h23: begin e.alu = ALUCTRL_ADD; e.mw = 1'b1; e.asrc = 1'b1; end
      7'h63: begin
        e.br = 1'b1;
        if (f3 == 3'd2 || f3 == 3'd3) ill = 1'b1;
        else e.alu = bbase[f3];
      end
      7'h6F: begin e.alu = ALUCTRL_JAL;  e.br = 1'b1; e.asrc = 1'b1; e.rw = 1'b1; end
      7'h67: begin e.alu = ALUCTRL_JALR; e.br = 1'b1; e.asrc = 1'b1; e.rw = 1'b1; end
      7'h17, 7'h37: begin e.alu = ALUCTRL_ADD; e.asrc = 1'b1; e.rw = 1'b1; end
      default: ill = 1'b1;
    endcase
    if (ill) begin
      e = '0;
      e.ill = 1'b1;
    end else begin
      e.rd = i[11:7];
      if (e.rd == 5'd0) e.rw = 1'b0;
    end
    return e;
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [31:0] i;
    logic [6:0] ops [11];
    logic [6:0] f7s [3];
    ops = '{7'h33, 7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h6F, 7'h67, 7'h17, 7'h37, 7'h7F};
    f7s = '{7'h00, 7'h20, 7'h01};
    i = $urandom;
    i[6:0] = ops[$urandom_range(0, 10)];
    if ($urandom_range(0, 3) != 0) i[31:25] = f7s[$urandom_range(0, 2)];
    return i;
  endfunction

  // One clock: drive at negedge, check 1 time unit later, advance the model.
  task automatic step(input bit iv, input logic [31:0] ins, input bit ordy, input bit fl);
    bit exp_rdy, mc;
    @(negedge clk);
    in_valid = iv; instr = ins; out_ready = ordy; flush = fl;
    #1;
    mc = m_valid && ((m_ent.mk == 2'd1 && MUL_LAT != 0) || (m_ent.mk == 2'd2 && DIV_LAT != 0));
    exp_rdy = (m_busy == 0) && !fl && (!m_valid || (ordy && !mc));
    chk("in_ready", {31'd0, in_ready}, {31'd0, exp_rdy});
    chk("out_valid", {31'd0, out_valid}, {31'd0, m_valid});
    chk("mext_busy", {31'd0, mext_busy}, {31'd0, (m_busy != 0)});
    if (m_valid)
      chk("bundle", {15'd0, alu_ctrl, branch, mem_read, mem_to_reg, mem_write, alu_src, reg_write, rd, illegal},
          {15'd0, m_ent.alu, m_ent.br, m_ent.mr, m_ent.m2r, m_ent.mw, m_ent.asrc, m_ent.rw, m_ent.rd, m_ent.ill});
    if (m_busy > 0) m_busy = m_busy - 1;
    else if (m_valid && ordy && !fl && mc) m_busy = (m_ent.mk == 2'd1) ? MUL_LAT : DIV_LAT;
    last_acc = iv && exp_rdy;
    if (fl) m_valid = 1'b0;
    else if (last_acc) begin m_valid = 1'b1; m_ent = ref_dec(ins, 1'b1); end
    else if (ordy) m_valid = 1'b0;
  endtask

  initial begin
    exp_t e2;
    logic [16:0] snap;
    int k;
    rst = 1'b1; in_valid = 1'b0; instr = '0; flush = 1'b0; out_ready = 1'b0;
    in_valid2 = 1'b0; instr2 = '0; flush2 = 1'b0; out_ready2 = 1'b0;
    m_valid = 1'b0; m_busy = 0; m_ent = '0; last_acc = 1'b0;
    #2;
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_alu", {27'd0, alu_ctrl}, {27'd0, ALUCTRL_NOP});
    chk("rst_ctrl", {25'd0, branch, mem_read, mem_to_reg, mem_write, alu_src, reg_write, illegal}, 32'd0);
    chk("rst_rd", {27'd0, rd}, 32'd0);
    chk("rst_busy", {31'd0, mext_busy}, 32'd0);
    @(negedge clk); @(negedge clk);
    rst = 1'b0;

    // 1: back-to-back ADD stream
    for (int n = 0; n < 3; n++) step(1'b1, I_ADD, 1'b1, 1'b0);
    chk("t1_alu", {27'd0, alu_ctrl}, {27'd0, ALUCTRL_ADD});
    chk("t1_rw", {31'd0, reg_write}, 32'd1);
    chk("t1_rd", {27'd0, rd}, 32'd1);
    step(1'b0, '0, 1'b1, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0);

    // 2: DIV occupies the unit for DIV_LAT cycles after handshake
    step(1'b1, I_DIV, 1'b0, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0);
    chk("t2_ready_t", {31'd0, in_ready}, 32'd0);
    k = 0;
    for (int n = 1; n <= 10; n++) begin
      step(1'b1, I_ADD, 1'b1, 1'b0);
      if (n <= DIV_LAT) chk("t2_busy", {31'd0, mext_busy}, 32'd1);
      if (last_acc && k == 0) k = n;
      if (k != 0) break;
    end
    chk("t2_accept_cycle", k, DIV_LAT + 1);
    step(1'b0, '0, 1'b1, 1'b0);

    // 3: M op on an ENABLE_M=0 instance is illegal
    in_valid2 = 1'b1; instr2 = I_DIV; out_ready2 = 1'b0;
    step(1'b0, '0, 1'b1, 1'b0);
    e2 = ref_dec(I_DIV, 1'b0);
    chk("t3_valid", {31'd0, out_valid2}, 32'd1);
    chk("t3_illegal", {31'd0, illegal2}, 32'd1);
    chk("t3_rw", {31'd0, reg_write2}, 32'd0);
    chk("t3_alu", {27'd0, alu_ctrl2}, {27'd0, ALUCTRL_NOP});
    chk("t3_model", {16'd0, alu_ctrl2, branch2, mem_read2, mem_to_reg2, mem_write2, alu_src2, reg_write2, rd2, illegal2},
        {16'd0, e2.alu, e2.br, e2.mr, e2.m2r, e2.mw, e2.asrc, e2.rw, e2.rd, e2.ill});
    in_valid2 = 1'b0; out_ready2 = 1'b1;
    step(1'b0, '0, 1'b1, 1'b0);
    chk("t3_busy", {31'd0, mext_busy2}, 32'd0);
    chk("t3_ready", {31'd0, in_ready2}, 32'd1);

    // 4: SW stalled by execute for three cycles
    step(1'b1, I_SW, 1'b0, 1'b0);
    step(1'b1, I_ADD, 1'b0, 1'b0);
    snap = {alu_ctrl, branch, mem_read, mem_to_reg, mem_write, alu_src, reg_write, rd};
    chk("t4_mw", {31'd0, mem_write}, 32'd1);
    chk("t4_rw", {31'd0, reg_write}, 32'd0);
    for (int n = 0; n < 2; n++) begin
      step(1'b1, I_ADD, 1'b0, 1'b0);
      chk("t4_stable", {15'd0, alu_ctrl, branch, mem_read, mem_to_reg, mem_write, alu_src, reg_write, rd}, {15'd0, snap});
      chk("t4_ready", {31'd0, in_ready}, 32'd0);
    end
    step(1'b0, '0, 1'b1, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0);
    chk("t4_consumed", {31'd0, out_valid}, 32'd0);

    // 5: flush of a held MUL does not start a wait
    step(1'b1, I_MUL, 1'b0, 1'b0);
    step(1'b0, '0, 1'b1, 1'b1);
    step(1'b1, I_ADDI, 1'b1, 1'b0);
    chk("t5_flushed", {31'd0, out_valid}, 32'd0);
    chk("t5_nobusy", {31'd0, mext_busy}, 32'd0);
    step(1'b0, '0, 1'b1, 1'b0);
    chk("t5_x0_rw", {31'd0, reg_write}, 32'd0);

    // 6: asynchronous reset in the middle of a DIV wait
    step(1'b1, I_DIV, 1'b1, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0);
    step(1'b0, '0, 1'b0, 1'b0);
    step(1'b0, '0, 1'b0, 1'b0);
    chk("t6_busy_before", {31'd0, mext_busy}, 32'd1);
    #1 rst = 1'b1;
    #1;
    chk("t6_busy", {31'd0, mext_busy}, 32'd0);
    chk("t6_valid", {31'd0, out_valid}, 32'd0);
    chk("t6_ctrl", {20'd0, alu_ctrl, branch, mem_write, reg_write, rd, illegal}, 32'd0);
    m_valid = 1'b0; m_busy = 0;
    @(posedge clk); #1 rst = 1'b0;
    step(1'b1, I_ADD, 1'b1, 1'b0);
    chk("t6_ready", {31'd0, in_ready}, 32'd1);

    // Random traffic against the model
    for (int n = 0; n < 400; n++)
      step(($urandom_range(0, 3) != 0), rand_instr(), ($urandom_range(0, 3) != 0), ($urandom_range(0, 15) == 0));

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
